// File: rtl/pipe_reg_chain_pkg.sv
// Shared types and helpers for the valid/ready register-slice chain.
package pipe_reg_chain_pkg;

  // Default payload width when an instance does not override it.
  localparam int DEFAULT_WIDTH  = 8;
  // Default number of chained slices.
  localparam int DEFAULT_STAGES = 1;

  // Fill state of one skid slice: nothing held, main register only, or main plus skid.
  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_MAIN  = 2'd1,
    SLICE_FULL  = 2'd2
  } slice_state_e;

  // Width of a counter that must represent 0 .. 2*stages inclusive.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle between an upstream stage, the register chain and a downstream stage.
interface pipe_reg_chain_if
  import pipe_reg_chain_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) ();

  localparam int OCC_W = occ_width(STAGES);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  // Surrounding pipeline: drives payload in, consumes payload out.
  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  // The register chain itself.
  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );

endinterface

// File: rtl/pipe_skid_slice.sv
// One 2-entry skid register slice. Ready depends only on registered state,
// so there is no combinational path from out_ready_i to in_ready_o, and
// none from the input payload to the output payload.
module pipe_skid_slice
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  slice_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             deliver;

  // Ready exactly while the skid slot is free; output always comes from the main register.
  assign in_ready_o  = (state_q != SLICE_FULL);
  assign out_valid_o = (state_q != SLICE_EMPTY);
  assign out_data_o  = main_q;

  assign accept  = in_valid_i & in_ready_o;
  assign deliver = out_valid_o & out_ready_i;

  // State and payload registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SLICE_EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state: fill main first, park in skid under backpressure, refill main from skid.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Flush wins over any handshake seen in the same cycle.
      state_d = SLICE_EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        SLICE_EMPTY: begin
          if (accept) begin
            main_d  = in_data_i;
            state_d = SLICE_MAIN;
          end
        end
        SLICE_MAIN: begin
          if (deliver) begin
            if (accept) begin
              main_d = in_data_i;
            end else begin
              state_d = SLICE_EMPTY;
            end
          end else if (accept) begin
            // Main is held downstream: the new item waits in the skid slot.
            skid_d  = in_data_i;
            state_d = SLICE_FULL;
          end
        end
        SLICE_FULL: begin
          // Ready was low, so no input can be taken here.
          if (deliver) begin
            main_d  = skid_q;
            state_d = SLICE_MAIN;
          end
        end
        default: begin
          state_d = SLICE_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain: STAGES skid slices in series with
// valid/ready flow control, synchronous flush and an entry-count output.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               STAGES      = DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  pipe_reg_chain_if.slave    bus
);

  localparam int OCC_W = occ_width(STAGES);

  // Link k feeds slice k; link STAGES is the chain output.
  logic             link_valid [STAGES+1];
  logic             link_ready [STAGES+1];
  logic [WIDTH-1:0] link_data  [STAGES+1];

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             chain_accept;
  logic             chain_deliver;

  assign link_valid[0]      = bus.in_valid;
  assign link_data[0]       = bus.in_data;
  assign bus.in_ready       = link_ready[0];
  assign bus.out_valid      = link_valid[STAGES];
  assign bus.out_data       = link_data[STAGES];
  assign link_ready[STAGES] = bus.out_ready;
  assign bus.occupancy      = occ_q;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slice
      pipe_skid_slice #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_slice (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (bus.flush),
        .in_valid_i  (link_valid[gi]),
        .in_ready_o  (link_ready[gi]),
        .in_data_i   (link_data[gi]),
        .out_valid_o (link_valid[gi+1]),
        .out_ready_i (link_ready[gi+1]),
        .out_data_o  (link_data[gi+1])
      );
    end
  endgenerate

  assign chain_accept  = bus.in_valid & link_ready[0];
  assign chain_deliver = link_valid[STAGES] & bus.out_ready;

  // Entry counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Count accepts minus deliveries at the chain boundary; flush empties everything.
  always_comb begin
    occ_d = occ_q;
    if (bus.flush) begin
      occ_d = '0;
    end else begin
      case ({chain_accept, chain_deliver})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a 2-stage and a 3-stage instance, a FIFO model
// checked on every falling edge, and directed checks with literal expectations.
module tb_pipe_reg_chain;

  logic clk  = 1'b0;
  logic rst2 = 1'b1;
  logic rst3 = 1'b1;

  always #5 clk = ~clk;

  pipe_reg_chain_if #(.WIDTH(8), .STAGES(2)) bus2 ();
  pipe_reg_chain_if #(.WIDTH(8), .STAGES(3)) bus3 ();

  pipe_reg_chain #(.WIDTH(8), .STAGES(2), .RESET_VALUE(8'h00)) dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2)
  );

  pipe_reg_chain #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h00)) dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (bus3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO model per instance (0 = 2 stages, 1 = 3 stages).
  logic [7:0] mdl_mem [2][256];
  int         mdl_wr  [2];
  int         mdl_rd  [2];
  int         acc_tot [2];
  int         del_tot [2];
  logic       stall_prev [2];
  logic [7:0] stall_data [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int k, input int cap, input logic rst, input logic fl,
                     input logic iv, input logic ir, input logic [7:0] id,
                     input logic ov, input logic ordy, input logic [7:0] od, input int occ);
    int size;
    if (!rst) begin
      chk("rst_valid", 32'(ov), 32'd0);
      chk("rst_data", 32'(od), 32'h00);
      chk("rst_ready", 32'(ir), 32'd1);
      chk("rst_occ", 32'(occ), 32'd0);
      mdl_rd[k]     = mdl_wr[k];
      stall_prev[k] = 1'b0;
    end else begin
      size = mdl_wr[k] - mdl_rd[k];
      chk("occ_model", 32'(occ), 32'(size));
      if (size == 0) chk("valid_when_empty", 32'(ov), 32'd0);
      if (ov && size > 0) chk("fifo_order", 32'(od), 32'(mdl_mem[k][mdl_rd[k] & 255]));
      if (size >= cap) chk("ready_when_full", 32'(ir), 32'd0);
      if (stall_prev[k]) begin
        chk("stall_valid", 32'(ov), 32'd1);
        chk("stall_data", 32'(od), 32'(stall_data[k]));
      end
      stall_prev[k] = ov & ~ordy & ~fl;
      stall_data[k] = od;
      if (fl) begin
        mdl_rd[k] = mdl_wr[k];
      end else begin
        if (ov && ordy && size > 0) begin
          mdl_rd[k]++;
          del_tot[k]++;
        end
        if (iv && ir) begin
          mdl_mem[k][mdl_wr[k] & 255] = id;
          mdl_wr[k]++;
          acc_tot[k]++;
        end
      end
    end
  endtask

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    mon(0, 4, rst2, bus2.flush, bus2.in_valid, bus2.in_ready, bus2.in_data,
        bus2.out_valid, bus2.out_ready, bus2.out_data, int'(bus2.occupancy));
    mon(1, 6, rst3, bus3.flush, bus3.in_valid, bus3.in_ready, bus3.in_data,
        bus3.out_valid, bus3.out_ready, bus3.out_data, int'(bus3.occupancy));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, last, nval, nacc, guard, a0, d0, lat;
    for (int k = 0; k < 2; k++) begin
      mdl_wr[k] = 0; mdl_rd[k] = 0; acc_tot[k] = 0; del_tot[k] = 0;
      stall_prev[k] = 1'b0; stall_data[k] = 8'h00;
    end

    // 1: reset held with input offered
    rst2 = 1'b0; rst3 = 1'b0;
    bus2.flush = 1'b0; bus2.in_valid = 1'b1; bus2.in_data = 8'hA5; bus2.out_ready = 1'b0;
    bus3.flush = 1'b0; bus3.in_valid = 1'b1; bus3.in_data = 8'hA5; bus3.out_ready = 1'b0;
    repeat (3) tick();
    chk("t1_valid", 32'(bus2.out_valid), 32'd0);
    chk("t1_data", 32'(bus2.out_data), 32'h00);
    chk("t1_ready", 32'(bus2.in_ready), 32'd1);
    chk("t1_occ", 32'(bus2.occupancy), 32'd0);
    chk("t1_valid3", 32'(bus3.out_valid), 32'd0);
    rst2 = 1'b1; rst3 = 1'b1;
    bus2.in_valid = 1'b0; bus3.in_valid = 1'b0;
    tick();

    // 2: streaming 01..0A through 3 stages
    bus3.out_ready = 1'b1;
    first = -1; last = -1; nval = 0;
    for (int t = 1; t <= 16; t++) begin
      bus3.in_valid = (t <= 10);
      bus3.in_data  = 8'(t);
      if (t <= 10) chk("t2_in_ready", 32'(bus3.in_ready), 32'd1);
      tick();
      if (bus3.out_valid) begin
        if (first < 0) first = t;
        last = t;
        chk("t2_data", 32'(bus3.out_data), 32'(nval + 1));
        nval++;
      end
      if (t >= 3 && t <= 10) chk("t2_occ", 32'(bus3.occupancy), 32'd3);
    end
    bus3.in_valid = 1'b0;
    chk("t2_first_cycle", 32'(first), 32'd3);
    chk("t2_count", 32'(nval), 32'd10);
    chk("t2_consecutive", 32'(last - first + 1), 32'd10);

    // 3: backpressure on 2 stages
    bus2.out_ready = 1'b0;
    nacc = 0; guard = 0;
    while (bus2.in_ready && guard < 20) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = 8'((nacc + 1) * 17);
      tick();
      nacc++; guard++;
    end
    bus2.in_valid = 1'b0;
    chk("t3_accepted", 32'(nacc), 32'd4);
    chk("t3_occ", 32'(bus2.occupancy), 32'd4);
    repeat (3) begin
      tick();
      chk("t3_hold_valid", 32'(bus2.out_valid), 32'd1);
      chk("t3_hold_data", 32'(bus2.out_data), 32'h11);
    end
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        chk("t3_drain_valid", 32'(bus2.out_valid), 32'd1);
        chk("t3_drain_data", 32'(bus2.out_data), 32'((i + 1) * 17));
      end else begin
        chk("t3_drain_end", 32'(bus2.out_valid), 32'd0);
      end
      tick();
      if (i == 0) chk("t3_ready_still_low", 32'(bus2.in_ready), 32'd0);
      if (i == 1) chk("t3_ready_back", 32'(bus2.in_ready), 32'd1);
    end

    // 4: random valid/ready on both instances
    a0 = acc_tot[0]; d0 = del_tot[0];
    for (int c = 0; c < 1000; c++) begin
      bus2.in_valid  = ($urandom_range(0, 9) < 6);
      bus2.in_data   = 8'($urandom);
      bus2.out_ready = ($urandom_range(0, 9) < 5);
      bus3.in_valid  = ($urandom_range(0, 9) < 5);
      bus3.in_data   = 8'($urandom);
      bus3.out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b1;
    repeat (20) tick();
    chk("t4_drain_occ", 32'(bus2.occupancy), 32'd0);
    chk("t4_drain_occ3", 32'(bus3.occupancy), 32'd0);
    chk("t4_no_loss", 32'(acc_tot[0] - a0), 32'(del_tot[0] - d0));
    chk("t4_traffic", 32'((acc_tot[0] - a0) > 100), 32'd1);

    // 5: flush with 3 held and a same-cycle accept and deliver
    bus2.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = 8'(8'h51 + i);
      tick();
    end
    bus2.in_valid = 1'b0;
    chk("t5_held", 32'(bus2.occupancy), 32'd3);
    bus2.flush = 1'b1; bus2.in_valid = 1'b1; bus2.in_data = 8'hEE; bus2.out_ready = 1'b1;
    tick();
    bus2.flush = 1'b0; bus2.in_valid = 1'b0;
    chk("t5_valid", 32'(bus2.out_valid), 32'd0);
    chk("t5_occ", 32'(bus2.occupancy), 32'd0);
    chk("t5_ready", 32'(bus2.in_ready), 32'd1);
    chk("t5_data", 32'(bus2.out_data), 32'h00);
    repeat (6) begin
      tick();
      chk("t5_no_leak", 32'(bus2.out_valid), 32'd0);
    end

    // 6: async reset between edges with 4 held
    bus2.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_fill_ready", 32'(bus2.in_ready), 32'd1);
      bus2.in_valid = 1'b1;
      bus2.in_data  = 8'(8'h61 + i);
      tick();
    end
    bus2.in_valid = 1'b0;
    chk("t6_held", 32'(bus2.occupancy), 32'd4);
    #2 rst2 = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus2.out_valid), 32'd0);
    chk("t6_async_occ", 32'(bus2.occupancy), 32'd0);
    chk("t6_async_ready", 32'(bus2.in_ready), 32'd1);
    chk("t6_async_data", 32'(bus2.out_data), 32'h00);
    tick();
    rst2 = 1'b1;
    bus2.in_valid = 1'b1; bus2.in_data = 8'h3C; bus2.out_ready = 1'b1;
    lat = -1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 1) bus2.in_valid = 1'b0;
      if (bus2.out_valid && lat < 0) begin
        lat = t;
        chk("t6_first_data", 32'(bus2.out_data), 32'h3C);
      end
    end
    chk("t6_latency", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
